spi_master_byte: RTL

- Byte-level SPI master, mode 3 (CPOL=1, CPHA=1), MSB first.
- Converts a parallel byte request into one SS-framed 8-bit SPI transfer and returns the byte read from MISO.
- It is the initiator counterpart to our mode-3 slave byte interface: it drives SCLK/SS/MOSI and samples MISO, all in the sysClk domain.
- Lets the FPGA talk to SPI peripherals and gives the slave block a loopback test partner.

---
 rtl/spi_master_byte.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_master_byte.sv
// Byte-wide SPI master, mode 3 (CPOL=1, CPHA=1), MSB first.
// Frame: LEAD, 8 SCLK low/high pairs, TRAIL, then a deselect GAP; every phase lasts CLK_DIV sysClk cycles.
module spi_master_byte #(
  parameter int CLK_DIV = 8
) (
  input  logic       sysClk,
  input  logic       usrReset,
  input  logic       txStart,
  input  logic [7:0] tx,
  output logic       txReady,
  output logic [7:0] rx,
  output logic       rxValid,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [6:0] tx_sh_q, tx_sh_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_q, rx_d;
  logic       sclk_q, sclk_d;
  logic       ss_q, ss_d;
  logic       mosi_q, mosi_d;
  logic       ready_q, ready_d;
  logic       valid_q, valid_d;
  logic       phase_end;
  logic       accept;

  assign phase_end = (phase_q == PHASE_LAST);
  // The end of GAP doubles as an accept slot so a held txStart streams frames with no idle cycle.
  assign accept = txStart && ((state_q == IDLE) || ((state_q == GAP) && phase_end));

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      state_q <= IDLE;
      phase_q <= 8'd0;
      bit_q   <= 3'd0;
      tx_sh_q <= 7'd0;
      rx_sh_q <= 7'd0;
      rx_q    <= 8'h00;
      sclk_q  <= 1'b1;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_end ? 8'd0 : phase_q + 8'd1;
    bit_d   = bit_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = 8'd0;
        ready_d = 1'b1;
      end
      LEAD: begin
        if (phase_end) begin
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_end) begin
          if (sclk_q) begin
            sclk_d  = 1'b0;
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
          end else begin
            // Rising edge: MISO has been stable since the slave's falling-edge update.
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[5:0], MISO};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rx_d    = {rx_sh_q, MISO};
              valid_d = 1'b1;
              state_d = TRAIL;
            end
          end
        end
      end
      TRAIL: begin
        if (phase_end) begin
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (phase_end) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      tx_sh_d = tx[6:0];
      mosi_d  = tx[7];
      ss_d    = 1'b0;
      ready_d = 1'b0;
      phase_d = 8'd0;
      bit_d   = 3'd0;
      state_d = LEAD;
    end
  end

  assign txReady = ready_q;
  assign rx      = rx_q;
  assign rxValid = valid_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

endmodule
